// File: rtl/nn_inference_core_if.sv
// ---------------------------------------------------------------------------
// nn_inference_core_if
//
// Purpose: groups the ap_ctrl_hs handshake and the data bus of the
// nn_inference_core so the core and whatever drives it share one bundle.
// Clock and reset stay outside the interface as plain ports of the core.
//
// Signals:
//   ap_start               start request (driver -> core)
//   ap_done                one-cycle pulse, result valid (core -> driver)
//   ap_idle                high while the core is idle (core -> driver)
//   ap_ready               high in the cycle the input is accepted
//   input_2_V_ap_vld       input word valid (driver -> core)
//   input_2_V[35:0]        [17:0]=x0, [35:18]=x1, signed Q8.10
//   layer7_out_0_V[17:0]   result y, signed Q8.10 (core -> driver)
//   layer7_out_0_V_ap_vld  result valid, same timing as ap_done
//
// Modports:
//   master  the side that issues requests (upstream block / testbench)
//   slave   the inference core itself
// ---------------------------------------------------------------------------
interface nn_inference_core_if;

  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic        input_2_V_ap_vld;
  logic [35:0] input_2_V;
  logic [17:0] layer7_out_0_V;
  logic        layer7_out_0_V_ap_vld;

  modport master (
    output ap_start,
    output input_2_V_ap_vld,
    output input_2_V,
    input  ap_done,
    input  ap_idle,
    input  ap_ready,
    input  layer7_out_0_V,
    input  layer7_out_0_V_ap_vld
  );

  modport slave (
    input  ap_start,
    input  input_2_V_ap_vld,
    input  input_2_V,
    output ap_done,
    output ap_idle,
    output ap_ready,
    output layer7_out_0_V,
    output layer7_out_0_V_ap_vld
  );

endinterface

// File: rtl/nn_inference_core.sv
// ---------------------------------------------------------------------------
// nn_inference_core
//
// Purpose: small fixed-point neural-network inference block with an
// ap_ctrl_hs style handshake. One 36-bit word carrying two signed Q8.10
// features is turned into one signed Q8.10 score through
//   Dense(2->4) -> ReLU -> Dense(4->1).
// One transaction is processed at a time with fixed latency: the hidden
// layer is registered in L1, the output layer in L2, and DONE presents the
// result for one cycle. With ap_start held high a new input is taken every
// fourth cycle.
//
// Ports:
//   ap_clk    clock, rising edge
//   ap_rst_n  asynchronous active-low reset (aborts any transaction)
//   bus       nn_inference_core_if.slave
//               ap_start / input_2_V_ap_vld / input_2_V in,
//               ap_done / ap_idle / ap_ready /
//               layer7_out_0_V / layer7_out_0_V_ap_vld out
//
// Parameters (all elements signed 18-bit Q8.10, element k at [18k+17:18k]):
//   W1  8 hidden weights; element 2j is neuron j's x0 weight and element
//       2j+1 its x1 weight. Defaults give n0=x0, n1=x1, n2=x0-x1, n3=x1-x0.
//   B1  4 hidden biases, element j for neuron j
//   W2  4 output weights, element j multiplies h_j (0.5, 0.5, 0.25, 0.25)
//   B2  output bias
// ---------------------------------------------------------------------------
module nn_inference_core #(
  parameter logic [143:0] W1 = {18'sd1024, -18'sd1024,   // n3: x1, x0
                                -18'sd1024, 18'sd1024,   // n2: x1, x0
                                18'sd1024,  18'sd0,      // n1: x1, x0
                                18'sd0,     18'sd1024},  // n0: x1, x0
  parameter logic [71:0]  B1 = 72'd0,
  parameter logic [71:0]  W2 = {18'sd256, 18'sd256, 18'sd512, 18'sd512},
  parameter logic [17:0]  B2 = 18'd0
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  nn_inference_core_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    L1,
    L2,
    DONE
  } state_t;

  state_t             state;
  logic signed [17:0] x0_q;
  logic signed [17:0] x1_q;
  logic signed [17:0] h_q [4];
  logic signed [17:0] y_q;
  logic               done_q;

  logic signed [17:0] h_d [4];
  logic signed [39:0] acc2;
  logic signed [17:0] y_d;
  logic               accept;

  // Full 36-bit Q16.20 product of two Q8.10 operands; both sides are
  // sign-extended first so the multiply is done at product width.
  function automatic logic signed [35:0] mul18(input logic signed [17:0] a,
                                              input logic signed [17:0] b);
    logic signed [35:0] ae;
    logic signed [35:0] be;
    ae = {{18{a[17]}}, a};
    be = {{18{b[17]}}, b};
    return ae * be;
  endfunction

  // Widen a product into the 40-bit accumulator.
  function automatic logic signed [39:0] ext40(input logic signed [35:0] p);
    return {{4{p[35]}}, p};
  endfunction

  // A Q8.10 bias lifted into Q16.20 so it lines up with the products.
  function automatic logic signed [39:0] bias40(input logic signed [17:0] b);
    return {{12{b[17]}}, b, 10'd0};
  endfunction

  // Back to Q8.10: the arithmetic shift floors toward -inf, then the value
  // is clamped to the 18-bit signed range.
  function automatic logic signed [17:0] rescale_sat(input logic signed [39:0] acc);
    logic signed [39:0] shifted;
    shifted = acc >>> 10;
    if (shifted > 40'sd131071) begin
      rescale_sat = 18'h1FFFF;
    end else if (shifted < -40'sd131072) begin
      rescale_sat = 18'h20000;
    end else begin
      rescale_sat = shifted[17:0];
    end
  endfunction

  // One hidden neuron: dense, saturate, then ReLU on the saturated value.
  function automatic logic signed [17:0] hidden_neuron(input logic signed [17:0] x0,
                                                      input logic signed [17:0] x1,
                                                      input logic signed [17:0] w0,
                                                      input logic signed [17:0] w1,
                                                      input logic signed [17:0] b);
    logic signed [17:0] s;
    s = rescale_sat(ext40(mul18(x0, w0)) + ext40(mul18(x1, w1)) + bias40(b));
    return s[17] ? 18'sd0 : s;
  endfunction

  // Input is taken only in IDLE when both start and valid are high.
  assign accept = (state == IDLE) && bus.ap_start && bus.input_2_V_ap_vld;

  // Hidden layer, evaluated from the captured features and registered in L1.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      h_d[j] = hidden_neuron(x0_q, x1_q,
                             W1[36*j +: 18], W1[36*j+18 +: 18],
                             B1[18*j +: 18]);
    end
  end

  // Output layer, evaluated from the registered hidden activations in L2.
  always_comb begin
    acc2 = bias40(B2);
    for (int j = 0; j < 4; j++) begin
      acc2 = acc2 + ext40(mul18(h_q[j], W2[18*j +: 18]));
    end
    y_d = rescale_sat(acc2);
  end

  // Control FSM and all datapath registers. The done pulse is registered
  // on the L2 -> DONE edge so it lines up with the freshly written result,
  // and an asynchronous reset clears everything, dropping any pending done.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= IDLE;
      x0_q   <= '0;
      x1_q   <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
      for (int j = 0; j < 4; j++) begin
        h_q[j] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x0_q  <= bus.input_2_V[17:0];
            x1_q  <= bus.input_2_V[35:18];
            state <= L1;
          end
        end
        L1: begin
          for (int j = 0; j < 4; j++) begin
            h_q[j] <= h_d[j];
          end
          state <= L2;
        end
        L2: begin
          y_q    <= y_d;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ap_done               = done_q;
  assign bus.layer7_out_0_V_ap_vld = done_q;
  assign bus.ap_idle               = (state == IDLE);
  assign bus.ap_ready              = accept;
  assign bus.layer7_out_0_V        = y_q;

endmodule

// File: tb/tb_nn_inference_core.sv
// ---------------------------------------------------------------------------
// tb_nn_inference_core
//
// Drives nn_inference_core through its interface with directed and
// $urandom stimulus. Each accepted input pushes its expected score and the
// cycle it must appear in onto a scoreboard queue; an independent monitor
// pops and compares whenever the core flags a result.
// ---------------------------------------------------------------------------
module tb_nn_inference_core;

  logic ap_clk = 1'b0;
  logic ap_rst_n;

  nn_inference_core_if bus ();

  nn_inference_core dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int cycle = 0;
  always @(posedge ap_clk) cycle <= cycle + 1;

  typedef struct {
    longint y;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;

  // Network as plain numbers: neuron j = W1X0[j]*x0 + W1X1[j]*x1 + B1V[j]
  longint W1X0 [4] = '{1024, 0, 1024, -1024};
  longint W1X1 [4] = '{0, 1024, -1024, 1024};
  longint B1V  [4] = '{0, 0, 0, 0};
  longint W2V  [4] = '{512, 512, 256, 256};
  longint B2V      = 0;

  function automatic longint sat18(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic longint refModel(input longint x0, input longint x1);
    longint h [4];
    longint acc;
    for (int j = 0; j < 4; j++) begin
      acc  = W1X0[j] * x0 + W1X1[j] * x1 + B1V[j] * 1024;
      h[j] = sat18(acc >>> 10);
      if (h[j] < 0) h[j] = 0;
    end
    acc = B2V * 1024;
    for (int j = 0; j < 4; j++) acc = acc + W2V[j] * h[j];
    return sat18(acc >>> 10);
  endfunction

  function automatic logic [17:0] randX();
    case ($urandom_range(0, 4))
      0:       return 18'h1FFFF;
      1:       return 18'h20000;
      2:       return 18'($urandom_range(0, 4095)) - 18'd2048;
      default: return 18'($urandom());
    endcase
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: any flagged result must match the oldest pending
  // expectation, both in value and in the cycle it shows up.
  always @(negedge ap_clk) begin : monitor
    exp_t   e;
    longint yv;
    if (ap_rst_n === 1'b1 && (bus.ap_done === 1'b1 || bus.layer7_out_0_V_ap_vld === 1'b1)) begin
      checkOutput("done_eq_vld", longint'(bus.ap_done), longint'(bus.layer7_out_0_V_ap_vld));
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e  = sb.pop_front();
        yv = $signed(bus.layer7_out_0_V);
        checkOutput("y", yv, e.y);
        checkOutput("latency", cycle, e.cyc);
      end
    end
  end

  task automatic waitDrain();
    for (int i = 0; i < 12; i++) begin
      if (sb.size() == 0) break;
      @(negedge ap_clk);
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // One start/valid pulse, then wait for the result and confirm it holds.
  task automatic applyStimulus(input logic [17:0] x0, input logic [17:0] x1, input longint expY);
    exp_t   e;
    longint yv;
    @(posedge ap_clk); #1;
    bus.ap_start         = 1'b1;
    bus.input_2_V_ap_vld = 1'b1;
    bus.input_2_V        = {x1, x0};
    @(negedge ap_clk);
    checkOutput("ready", longint'(bus.ap_ready), 1);
    if (bus.ap_ready === 1'b1) begin
      e.y   = expY;
      e.cyc = cycle + 3;
      sb.push_back(e);
    end
    @(posedge ap_clk); #1;
    bus.ap_start         = 1'b0;
    bus.input_2_V_ap_vld = 1'b0;
    bus.input_2_V        = 36'($urandom());
    waitDrain();
    @(negedge ap_clk);
    yv = $signed(bus.layer7_out_0_V);
    checkOutput("hold", yv, expY);
    checkOutput("idle_after", longint'(bus.ap_idle), 1);
  endtask

  initial begin
    int     prevAcc;
    int     nAcc;
    longint yv;
    logic [17:0] rx0;
    logic [17:0] rx1;

    ap_rst_n             = 1'b1;
    bus.ap_start         = 1'b0;
    bus.input_2_V_ap_vld = 1'b0;
    bus.input_2_V        = '0;

    // Asynchronous reset away from any clock edge
    #3 ap_rst_n = 1'b0;
    #1;
    yv = $signed(bus.layer7_out_0_V);
    checkOutput("rst_idle", longint'(bus.ap_idle), 1);
    checkOutput("rst_done", longint'(bus.ap_done), 0);
    checkOutput("rst_y", yv, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    yv = $signed(bus.layer7_out_0_V);
    checkOutput("post_rst_idle", longint'(bus.ap_idle), 1);
    checkOutput("post_rst_ready", longint'(bus.ap_ready), 0);
    checkOutput("post_rst_vld", longint'(bus.layer7_out_0_V_ap_vld), 0);
    checkOutput("post_rst_y", yv, 0);

    // Directed vectors with hand-derived scores
    applyStimulus(18'd1024, 18'd2048, 1792);
    applyStimulus(18'h3FC00, 18'd0, 256);
    applyStimulus(18'd1, 18'd0, 0);
    applyStimulus(18'h1FFFF, 18'h20000, 98303);

    // Start without valid: nothing may happen
    @(posedge ap_clk); #1;
    bus.ap_start         = 1'b1;
    bus.input_2_V_ap_vld = 1'b0;
    bus.input_2_V        = {18'd2048, 18'd1024};
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      checkOutput("wait_idle", longint'(bus.ap_idle), 1);
      checkOutput("wait_ready", longint'(bus.ap_ready), 0);
      @(posedge ap_clk); #1;
    end

    // Start and valid held high with new data every cycle
    prevAcc = -1;
    nAcc    = 0;
    for (int i = 0; i < 40; i++) begin
      rx0 = randX();
      rx1 = randX();
      bus.input_2_V_ap_vld = 1'b1;
      bus.input_2_V        = {rx1, rx0};
      @(negedge ap_clk);
      if (bus.ap_ready === 1'b1) begin
        exp_t e;
        e.y   = refModel($signed(rx0), $signed(rx1));
        e.cyc = cycle + 3;
        sb.push_back(e);
        if (prevAcc >= 0) checkOutput("spacing", cycle - prevAcc, 4);
        prevAcc = cycle;
        nAcc++;
      end
      @(posedge ap_clk); #1;
    end
    bus.ap_start         = 1'b0;
    bus.input_2_V_ap_vld = 1'b0;
    checkOutput("accept_count", nAcc, 10);
    waitDrain();

    // Reset while the core sits in L2: no result, idle at once
    @(posedge ap_clk); #1;
    bus.ap_start         = 1'b1;
    bus.input_2_V_ap_vld = 1'b1;
    bus.input_2_V        = {18'd2048, 18'd1024};
    @(negedge ap_clk);
    checkOutput("ready_abort", longint'(bus.ap_ready), 1);
    @(posedge ap_clk); #1;
    bus.ap_start         = 1'b0;
    bus.input_2_V_ap_vld = 1'b0;
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b0;
    #1;
    yv = $signed(bus.layer7_out_0_V);
    checkOutput("abort_idle", longint'(bus.ap_idle), 1);
    checkOutput("abort_done", longint'(bus.ap_done), 0);
    checkOutput("abort_y", yv, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ap_clk);
      checkOutput("abort_no_done", longint'(bus.ap_done), 0);
    end
    applyStimulus(18'd1024, 18'd2048, 1792);

    // Randomized single transactions with idle gaps
    for (int i = 0; i < 30; i++) begin
      rx0 = randX();
      rx1 = randX();
      repeat ($urandom_range(0, 3)) @(posedge ap_clk);
      applyStimulus(rx0, rx1, refModel($signed(rx0), $signed(rx1)));
    end

    waitDrain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
